// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential advance, stall hold, and prioritised
// csr/trap/branch redirects with a pending slot and a counted flush.
module pc_redirect_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_ready,
  input  logic        stall,
  input  logic        csr_req,
  input  logic [63:0] csr_target,
  input  logic        trap_req,
  input  logic [63:0] trap_target,
  input  logic        br_req,
  input  logic [63:0] br_target,
  output logic [63:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        redirect,
  output logic [1:0]  redirect_src,
  output logic        busy,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] tgt;
  } redir_t;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_CSR  = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_BR   = 2'b11;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // Higher rank wins; SRC_SEQ ranks below everything so an empty slot is replaceable.
  function automatic logic [1:0] rank(input logic [1:0] src);
    case (src)
      SRC_CSR:  rank = 2'd3;
      SRC_TRAP: rank = 2'd2;
      SRC_BR:   rank = 2'd1;
      default:  rank = 2'd0;
    endcase
  endfunction

  state_t     state;
  redir_t     pend;
  logic [3:0] flush_cnt;

  redir_t req;
  logic   req_vld;
  logic   replace;
  logic   take_vld;
  redir_t take;

  // Branches seen during FLUSH belong to squashed instructions and are masked.
  always_comb begin
    req     = '0;
    req_vld = 1'b0;
    if (csr_req) begin
      req_vld = 1'b1;
      req.src = SRC_CSR;
      req.tgt = csr_target & ~64'd1;
    end else if (trap_req) begin
      req_vld = 1'b1;
      req.src = SRC_TRAP;
      req.tgt = trap_target & ~64'd1;
    end else if (br_req && state != FLUSH) begin
      req_vld = 1'b1;
      req.src = SRC_BR;
      req.tgt = br_target & ~64'd1;
    end
  end

  always_comb begin
    replace  = (state == HOLD) && req_vld && (rank(req.src) > rank(pend.src));
    take_vld = if_ready && ((state == HOLD) || req_vld);
    take     = ((state == HOLD) && !replace) ? pend : req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      redirect_src <= SRC_SEQ;
      busy         <= 1'b0;
      redirect_cnt <= '0;
      flush_cnt    <= '0;
      pend         <= '0;
    end else begin
      redirect <= 1'b0;
      if (take_vld) begin
        pc           <= take.tgt;
        redirect_src <= take.src;
        redirect     <= 1'b1;
        flush        <= 1'b1;
        flush_cnt    <= FLUSH_LOAD;
        pc_valid     <= 1'b1;
        busy         <= 1'b0;
        state        <= FLUSH;
        pend         <= '0;
        if (redirect_cnt != 16'hFFFF)
          redirect_cnt <= redirect_cnt + 16'd1;
      end else if (state == HOLD) begin
        if (replace)
          pend <= req;
      end else if (req_vld) begin
        pend     <= req;
        state    <= HOLD;
        pc_valid <= 1'b0;
        busy     <= 1'b1;
        flush    <= 1'b0;
      end else begin
        pc_valid <= 1'b1;
        // The reset PC is only presented once pc_valid is up, so it is not skipped.
        if (if_ready && !stall && pc_valid) begin
          pc           <= pc + 64'd4;
          redirect_src <= SRC_SEQ;
        end
        if (state == FLUSH) begin
          if (flush_cnt == 4'd0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
      end
    end
  end

endmodule
